mibench_mul_arbiter: RTL and testbench

MIBENCH_MUL_ARBITER -- requirements
Module: mibench_mul_arbiter

---
 rtl/mibench_mul_pkg.sv | 30 +++
 rtl/mibench_mul_core.sv | 25 ++
 rtl/mibench_mul_arbiter.sv | 142 ++++++++++++++
 tb/tb_mibench_mul_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mibench_mul_pkg.sv
// Shared defaults, saturation limits and pipeline stage records for the
// multiplier arbiter.
`default_nettype none

package mibench_mul_pkg;

   localparam int MUL_NUM_REQ    = 4;
   localparam int MUL_DATA_WIDTH = 16;
   localparam int MUL_ID_WIDTH   = $clog2(MUL_NUM_REQ);

   localparam logic [MUL_DATA_WIDTH-1:0] MUL_SAT_MAX = {1'b0, {(MUL_DATA_WIDTH-1){1'b1}}};
   localparam logic [MUL_DATA_WIDTH-1:0] MUL_SAT_MIN = {1'b1, {(MUL_DATA_WIDTH-1){1'b0}}};

   typedef struct packed {
      logic                             valid;
      logic [MUL_ID_WIDTH-1:0]          id;
      logic signed [MUL_DATA_WIDTH-1:0] a;
      logic signed [MUL_DATA_WIDTH-1:0] b;
   } s1_rec_t;

   typedef struct packed {
      logic                      valid;
      logic [MUL_ID_WIDTH-1:0]   id;
      logic [MUL_DATA_WIDTH-1:0] p;
      logic                      ovf;
   } s2_rec_t;

endpackage

`default_nettype wire

// File: rtl/mibench_mul_core.sv
// Combinational signed multiply: full double-width product plus a flag for
// products that do not fit in DATA_WIDTH signed bits.
`default_nettype none

module mibench_mul_core
   import mibench_mul_pkg::*;
#(
   parameter int DATA_WIDTH = MUL_DATA_WIDTH
) (
   input  logic signed [DATA_WIDTH-1:0]   a_i,
   input  logic signed [DATA_WIDTH-1:0]   b_i,
   output logic signed [2*DATA_WIDTH-1:0] p_full_o,
   output logic                           ovf_o
);

   logic [DATA_WIDTH:0] hi_bits;

   assign p_full_o = a_i * b_i;
   // Fits iff the top DATA_WIDTH+1 bits are all copies of the sign bit.
   assign hi_bits  = p_full_o[2*DATA_WIDTH-1:DATA_WIDTH-1];
   assign ovf_o    = ~((&hi_bits) | ~(|hi_bits));

endmodule

`default_nettype wire

// File: rtl/mibench_mul_arbiter.sv
// Round-robin arbiter feeding a shared two-stage signed multiplier pipeline.
// Define MIBENCH_MUL_ARB_SATURATE_EN to saturate overflowing products.
`default_nettype none

module mibench_mul_arbiter
   import mibench_mul_pkg::*;
#(
   parameter int NUM_REQ    = MUL_NUM_REQ,
   parameter int DATA_WIDTH = MUL_DATA_WIDTH,
   parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic                          ap_clk,
   input  logic                          ap_rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out_p,
   output logic [ID_WIDTH-1:0]           out_id,
   output logic                          out_ovf
);

   localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic                  s1_valid_q, s1_valid_d;
   logic [ID_WIDTH-1:0]   s1_id_q, s1_id_d;
   logic [DATA_WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
   logic                  s2_valid_q, s2_valid_d;
   logic [ID_WIDTH-1:0]   s2_id_q, s2_id_d;
   logic [DATA_WIDTH-1:0] s2_p_q, s2_p_d;
   logic                  s2_ovf_q, s2_ovf_d;
   logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;

   logic                           grant_found;
   logic [ID_WIDTH-1:0]            grant_id;
   logic                           s2_load, s1_load, accept;
   logic signed [2*DATA_WIDTH-1:0] p_full;
   logic                           p_ovf;
   logic [DATA_WIDTH-1:0]          p_reduced;

   always_comb begin
      int idx;
      idx         = 0;
      grant_found = 1'b0;
      grant_id    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last_grant_q) + k) % NUM_REQ;
         if (!grant_found && req_valid[idx]) begin
            grant_found = 1'b1;
            grant_id    = ID_WIDTH'(idx);
         end
      end
   end

   assign s2_load   = s1_valid_q && (!s2_valid_q || out_ready);
   assign s1_load   = !s1_valid_q || s2_load;
   // Gated by reset so nothing looks accepted while the registers are held clear.
   assign accept    = grant_found && s1_load && ap_rst_n;
   assign req_ready = accept ? (NUM_REQ'(1) << grant_id) : '0;

   mibench_mul_core #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_core (
      .a_i      (s1_a_q),
      .b_i      (s1_b_q),
      .p_full_o (p_full),
      .ovf_o    (p_ovf)
   );

`ifdef MIBENCH_MUL_ARB_SATURATE_EN
   assign p_reduced = p_ovf ? (p_full[2*DATA_WIDTH-1] ? SAT_MIN : SAT_MAX)
                            : p_full[DATA_WIDTH-1:0];
`else
   assign p_reduced = p_full[DATA_WIDTH-1:0];
`endif

   always_comb begin
      s1_valid_d   = s1_valid_q;
      s1_id_d      = s1_id_q;
      s1_a_d       = s1_a_q;
      s1_b_d       = s1_b_q;
      s2_valid_d   = s2_valid_q;
      s2_id_d      = s2_id_q;
      s2_p_d       = s2_p_q;
      s2_ovf_d     = s2_ovf_q;
      last_grant_d = last_grant_q;

      if (s1_load) begin
         s1_valid_d = accept;
      end
      if (accept) begin
         s1_id_d      = grant_id;
         s1_a_d       = req_a[grant_id*DATA_WIDTH +: DATA_WIDTH];
         s1_b_d       = req_b[grant_id*DATA_WIDTH +: DATA_WIDTH];
         last_grant_d = grant_id;
      end

      if (s2_load) begin
         s2_valid_d = 1'b1;
         s2_id_d    = s1_id_q;
         s2_p_d     = p_reduced;
         s2_ovf_d   = p_ovf;
      end else if (out_ready) begin
         s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_id_q      <= '0;
         s1_a_q       <= '0;
         s1_b_q       <= '0;
         s2_valid_q   <= 1'b0;
         s2_id_q      <= '0;
         s2_p_q       <= '0;
         s2_ovf_q     <= 1'b0;
         last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_id_q      <= s1_id_d;
         s1_a_q       <= s1_a_d;
         s1_b_q       <= s1_b_d;
         s2_valid_q   <= s2_valid_d;
         s2_id_q      <= s2_id_d;
         s2_p_q       <= s2_p_d;
         s2_ovf_q     <= s2_ovf_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_p     = s2_p_q;
   assign out_id    = s2_id_q;
   assign out_ovf   = s2_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_mibench_mul_arbiter.sv
// Directed self-checking bench for mibench_mul_arbiter (4 requesters, 16-bit).
`default_nettype none

module tb_mibench_mul_arbiter;

   localparam int N = 4;
   localparam int W = 16;

   logic           ap_clk;
   logic           ap_rst_n;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_a;
   logic [N*W-1:0] req_b;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out_p;
   logic [1:0]     out_id;
   logic           out_ovf;

   int total;
   int bad;

   mibench_mul_arbiter #(
      .NUM_REQ    (N),
      .DATA_WIDTH (W),
      .ID_WIDTH   (2)
   ) dut (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .out_id    (out_id),
      .out_ovf   (out_ovf)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs are then driven at +1 and checked at +2.
   task automatic step();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic set_ops(input int idx, input int a, input int b);
      req_a[idx*W +: W] = 16'(a);
      req_b[idx*W +: W] = 16'(b);
   endtask

   task automatic do_single(input string tag, input int idx, input int a, input int b,
                            input logic [15:0] exp_p, input logic exp_ovf);
      set_ops(idx, a, b);
      req_valid = 4'(1 << idx);
      out_ready = 1'b1;
      #1;
      chk({tag, "_ready"}, 32'(req_ready), 32'(1 << idx));
      step();
      req_valid = '0;
      #1;
      chk({tag, "_early"}, 32'(out_valid), 32'd0);
      step();
      #1;
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_p"},     32'(out_p),     32'(exp_p));
      chk({tag, "_id"},    32'(out_id),    32'(idx));
      chk({tag, "_ovf"},   32'(out_ovf),   32'(exp_ovf));
      step();
      #1;
      chk({tag, "_drain"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      ap_rst_n  = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      out_ready = 1'b0;

      // Reset state, with a request pending to show req_ready held low.
      #2;
      req_valid = 4'b0001;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_p",     32'(out_p),     32'd0);
      chk("rst_out_id",    32'(out_id),    32'd0);
      chk("rst_out_ovf",   32'(out_ovf),   32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      req_valid = '0;
      step();
      ap_rst_n = 1'b1;
      step();

      // Single request, basic signed multiply.
      do_single("single", 2, 3, -4, 16'hFFF4, 1'b0);

      // Fresh reset, then all four valid: round robin from requester 0.
      ap_rst_n = 1'b0;
      step();
      ap_rst_n = 1'b1;
      for (int i = 0; i < N; i++) set_ops(i, i + 1, 10);
      out_ready = 1'b1;
      req_valid = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         if (c == 6) req_valid = '0;
         #1;
         if (c < 6) chk("rr_ready", 32'(req_ready), 32'(1 << (c % 4)));
         else       chk("rr_ready_idle", 32'(req_ready), 32'd0);
         if (c >= 2) begin
            chk("rr_valid", 32'(out_valid), 32'd1);
            chk("rr_id",    32'(out_id),    32'((c - 2) % 4));
            chk("rr_p",     32'(out_p),     32'((((c - 2) % 4) + 1) * 10));
         end else begin
            chk("rr_fill", 32'(out_valid), 32'd0);
         end
         step();
      end
      #1;
      chk("rr_drain", 32'(out_valid), 32'd0);
      step();

      // Overflow and boundary products.
`ifdef MIBENCH_MUL_ARB_SATURATE_EN
      do_single("ovf_pos",  0,    300,  200, 16'h7FFF, 1'b1);
      do_single("ovf_neg",  1,   -300,  200, 16'h8000, 1'b1);
      do_single("min_x1",   2, -32768,    1, 16'h8000, 1'b0);
      do_single("min_xm1",  2, -32768,   -1, 16'h7FFF, 1'b1);
`else
      do_single("ovf_pos",  0,    300,  200, 16'hEA60, 1'b1);
      do_single("ovf_neg",  1,   -300,  200, 16'h15A0, 1'b1);
      do_single("min_x1",   2, -32768,    1, 16'h8000, 1'b0);
      do_single("min_xm1",  2, -32768,   -1, 16'h8000, 1'b1);
`endif
      do_single("small",    3,      7,    5, 16'h0023, 1'b0);

      // Backpressure: last grant is 3, so requesters 0,1,2 win in order.
      for (int i = 0; i < 3; i++) set_ops(i, i + 2, 3);
      out_ready = 1'b0;
      req_valid = 4'b0111;
      #1;
      chk("bp_ready0", 32'(req_ready), 32'b0001);
      step();
      req_valid = 4'b0110;
      #1;
      chk("bp_ready1", 32'(req_ready), 32'b0010);
      step();
      req_valid = 4'b0100;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("bp_hold_ready", 32'(req_ready), 32'd0);
         chk("bp_hold_valid", 32'(out_valid), 32'd1);
         chk("bp_hold_id",    32'(out_id),    32'd0);
         chk("bp_hold_p",     32'(out_p),     32'd6);
         step();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_rel_ready", 32'(req_ready), 32'b0100);
      chk("bp_rel_id0",   32'(out_id),    32'd0);
      step();
      req_valid = '0;
      #1;
      chk("bp_out1_valid", 32'(out_valid), 32'd1);
      chk("bp_out1_id",    32'(out_id),    32'd1);
      chk("bp_out1_p",     32'(out_p),     32'd9);
      step();
      #1;
      chk("bp_out2_valid", 32'(out_valid), 32'd1);
      chk("bp_out2_id",    32'(out_id),    32'd2);
      chk("bp_out2_p",     32'(out_p),     32'd12);
      step();
      #1;
      chk("bp_empty", 32'(out_valid), 32'd0);

      // Reset while both stages are full.
      out_ready = 1'b0;
      req_valid = 4'b1111;
      step();
      step();
      #1;
      chk("mid_full_valid", 32'(out_valid), 32'd1);
      chk("mid_full_ready", 32'(req_ready), 32'd0);
      ap_rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_p",     32'(out_p),     32'd0);
      chk("mid_rst_ready", 32'(req_ready), 32'd0);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      #1;
      chk("post_rst_grant", 32'(req_ready), 32'b0001);
      step();
      req_valid = '0;
      out_ready = 1'b1;
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
